// File: rtl/ibex_fetch_fifo_wide.sv
// Prefetch FIFO for a 32/64-bit fetch bus that realigns stored words into 32-bit instructions.
// Optional macro FETCH_FIFO_BYPASS_EN feeds the input word straight to the output when entries are empty.
module ibex_fetch_fifo_wide #(
  parameter int unsigned NUM_REQS = 2,
  parameter int unsigned BUS_W    = 32
) (
  input  logic                              clk_i,
  input  logic                              rst_ni,
  input  logic                              clear_i,
  input  logic                              in_valid_i,
  output logic                              in_ready_o,
  input  logic [31:0]                       in_addr_i,
  input  logic [BUS_W-1:0]                  in_rdata_i,
  input  logic                              in_err_i,
  output logic                              out_valid_o,
  input  logic                              out_ready_i,
  output logic [31:0]                       out_addr_o,
  output logic [31:0]                       out_rdata_o,
  output logic                              out_err_o,
  output logic [$clog2(NUM_REQS+2)-1:0]     occupancy_o
);

  localparam int unsigned DEPTH = NUM_REQS + 1;
  localparam int unsigned NHW   = BUS_W / 16;
  localparam int unsigned HWB   = $clog2(NHW);
  localparam int unsigned OCC_W = $clog2(DEPTH + 1);
  localparam int unsigned SW    = HWB + 2;

  logic [DEPTH-1:0] valid_q, valid_d;
  logic [DEPTH-1:0] err_q, err_d;
  logic [BUS_W-1:0] rdata_q [DEPTH];
  logic [BUS_W-1:0] rdata_d [DEPTH];
  logic [31:1]      instr_addr_q, instr_addr_d;
  logic [OCC_W-1:0] occ_q, occ_d;

  logic [HWB-1:0]   hw, hw_nxt;
  logic             spanning, compressed;
  logic             head_vld, head_err, sec_vld, sec_err;
  logic [BUS_W-1:0] head_word;
  logic [15:0]      sec_hw, lo_hw, hi_hw;
  logic [SW-1:0]    hw_end;
  logic             xfer, pop, pop_st, push_req, push_done;
  logic             unused_addr_lsb;

  assign unused_addr_lsb = in_addr_i[0];

  assign hw       = instr_addr_q[HWB:1];
  assign hw_nxt   = hw + 1'b1;
  assign spanning = &hw;

`ifdef FETCH_FIFO_BYPASS_EN
  // An empty slot is filled by the bus word in flight, as head or as the spanning upper half.
  assign head_vld  = valid_q[0] | in_valid_i;
  assign head_word = valid_q[0] ? rdata_q[0] : in_rdata_i;
  assign head_err  = valid_q[0] ? err_q[0]   : in_err_i;
  assign sec_vld   = valid_q[1] | (valid_q[0] & in_valid_i);
  assign sec_hw    = valid_q[1] ? rdata_q[1][15:0] : in_rdata_i[15:0];
  assign sec_err   = valid_q[1] ? err_q[1]         : in_err_i;
`else
  assign head_vld  = valid_q[0];
  assign head_word = rdata_q[0];
  assign head_err  = err_q[0];
  assign sec_vld   = valid_q[1];
  assign sec_hw    = rdata_q[1][15:0];
  assign sec_err   = err_q[1];
`endif

  assign lo_hw      = head_word[16*hw +: 16];
  assign hi_hw      = spanning ? sec_hw : head_word[16*hw_nxt +: 16];
  assign compressed = (lo_hw[1:0] != 2'b11);

  assign out_valid_o = head_vld & (compressed | ~spanning | sec_vld);
  assign out_err_o   = head_err | (~compressed & spanning & sec_err);
  assign out_rdata_o = {hi_hw, lo_hw};
  assign out_addr_o  = {instr_addr_q, 1'b0};
  assign in_ready_o  = ~valid_q[DEPTH-NUM_REQS];
  assign occupancy_o = occ_q;

  assign xfer   = out_valid_o & out_ready_i;
  assign hw_end = SW'(hw) + (compressed ? SW'(1) : SW'(2));
  assign pop    = xfer & (hw_end >= SW'(NHW));
  // A pop with no stored head means the bypassed word was fully consumed and must not be stored.
  assign pop_st   = pop & valid_q[0];
  assign push_req = in_valid_i & ~(pop & ~valid_q[0]);

  always_comb begin
    valid_d      = valid_q;
    err_d        = err_q;
    rdata_d      = rdata_q;
    instr_addr_d = instr_addr_q;
    push_done    = 1'b0;

    if (xfer) begin
      instr_addr_d = instr_addr_q + (compressed ? 31'd1 : 31'd2);
    end

    if (pop_st) begin
      for (int i = 0; i < DEPTH - 1; i++) begin
        valid_d[i] = valid_q[i+1];
        err_d[i]   = err_q[i+1];
        rdata_d[i] = rdata_q[i+1];
      end
      valid_d[DEPTH-1] = 1'b0;
    end

    if (push_req) begin
      for (int i = 0; i < DEPTH; i++) begin
        if (!push_done && !valid_d[i]) begin
          valid_d[i] = 1'b1;
          err_d[i]   = in_err_i;
          rdata_d[i] = in_rdata_i;
          push_done  = 1'b1;
        end
      end
    end

    occ_d = occ_q + OCC_W'(push_done) - OCC_W'(pop_st);

    if (clear_i) begin
      valid_d      = '0;
      instr_addr_d = in_addr_i[31:1];
      occ_d        = '0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      valid_q      <= '0;
      instr_addr_q <= '0;
      occ_q        <= '0;
    end else begin
      valid_q      <= valid_d;
      instr_addr_q <= instr_addr_d;
      occ_q        <= occ_d;
    end
  end

  // Payload storage is qualified by valid_q and carries no reset.
  always_ff @(posedge clk_i) begin
    rdata_q <= rdata_d;
    err_q   <= err_d;
  end

endmodule

// File: tb/tb_ibex_fetch_fifo_wide.sv
// Scoreboard bench for ibex_fetch_fifo_wide: a 32-bit and a 64-bit bus instance driven with directed words.
module tb_ibex_fetch_fifo_wide;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic        a_clear, a_vld, a_err, a_ordy;
  logic [31:0] a_addr, a_rdata;
  logic        a_irdy, a_ovld, a_oerr;
  logic [31:0] a_oaddr, a_ordata;
  logic [1:0]  a_occ;

  logic        b_clear, b_vld, b_err, b_ordy;
  logic [31:0] b_addr;
  logic [63:0] b_rdata;
  logic        b_irdy, b_ovld, b_oerr;
  logic [31:0] b_oaddr, b_ordata;
  logic [1:0]  b_occ;

  ibex_fetch_fifo_wide #(.NUM_REQS(2), .BUS_W(32)) u_a (
    .clk_i(clk), .rst_ni(rst_n), .clear_i(a_clear), .in_valid_i(a_vld), .in_ready_o(a_irdy),
    .in_addr_i(a_addr), .in_rdata_i(a_rdata), .in_err_i(a_err), .out_valid_o(a_ovld),
    .out_ready_i(a_ordy), .out_addr_o(a_oaddr), .out_rdata_o(a_ordata), .out_err_o(a_oerr),
    .occupancy_o(a_occ)
  );

  ibex_fetch_fifo_wide #(.NUM_REQS(2), .BUS_W(64)) u_b (
    .clk_i(clk), .rst_ni(rst_n), .clear_i(b_clear), .in_valid_i(b_vld), .in_ready_o(b_irdy),
    .in_addr_i(b_addr), .in_rdata_i(b_rdata), .in_err_i(b_err), .out_valid_o(b_ovld),
    .out_ready_i(b_ordy), .out_addr_o(b_oaddr), .out_rdata_o(b_ordata), .out_err_o(b_oerr),
    .occupancy_o(b_occ)
  );

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] data;
    logic [31:0] mask;
    logic        err;
  } exp_t;

  exp_t qa[$];
  exp_t qb[$];
  int checks = 0;
  int errors = 0;

  localparam logic [31:0] FULL = 32'hFFFF_FFFF;
  localparam logic [31:0] HALF = 32'h0000_FFFF;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (rst_n && a_ovld && a_ordy) begin
      if (qa.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL a_unexpected: got output at 0x%08h expected none", a_oaddr);
      end else begin
        e = qa.pop_front();
        chk("a_addr", a_oaddr, e.addr);
        chk("a_data", a_ordata & e.mask, e.data);
        chk("a_err", 32'(a_oerr), 32'(e.err));
      end
    end
  end

  always @(negedge clk) begin
    exp_t e;
    if (rst_n && b_ovld && b_ordy) begin
      if (qb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL b_unexpected: got output at 0x%08h expected none", b_oaddr);
      end else begin
        e = qb.pop_front();
        chk("b_addr", b_oaddr, e.addr);
        chk("b_data", b_ordata & e.mask, e.data);
        chk("b_err", 32'(b_oerr), 32'(e.err));
      end
    end
  end

  always @(posedge clk) begin
    if (rst_n && !a_clear)
      assert (!(a_vld && a_occ == 2'd3)) else $error("protocol: push into full 32-bit fifo");
    if (rst_n && !b_clear)
      assert (!(b_vld && b_occ == 2'd3)) else $error("protocol: push into full 64-bit fifo");
  end

  task automatic ta(input logic clr, input logic v, input logic [31:0] ad,
                    input logic [31:0] rd, input logic e, input logic rdy);
    @(posedge clk);
    #1;
    a_clear = clr; a_vld = v; a_addr = ad; a_rdata = rd; a_err = e; a_ordy = rdy;
  endtask

  task automatic tb(input logic clr, input logic v, input logic [31:0] ad,
                    input logic [63:0] rd, input logic e, input logic rdy);
    @(posedge clk);
    #1;
    b_clear = clr; b_vld = v; b_addr = ad; b_rdata = rd; b_err = e; b_ordy = rdy;
  endtask

  task automatic drain_a(input string nm);
    int n = 0;
    while (qa.size() != 0 && n < 40) begin
      @(posedge clk);
      n++;
    end
    checks++;
    if (qa.size() != 0) begin
      errors++;
      $display("FAIL %s: got %0d outputs pending expected 0", nm, qa.size());
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "timeout");
  end

  initial begin
    a_clear = 0; a_vld = 0; a_addr = 0; a_rdata = 0; a_err = 0; a_ordy = 0;
    b_clear = 0; b_vld = 0; b_addr = 0; b_rdata = 0; b_err = 0; b_ordy = 0;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_a_occ", 32'(a_occ), 0);
    chk("rst_a_addr", a_oaddr, 0);
    chk("rst_a_vld", 32'(a_ovld), 0);
    chk("rst_a_irdy", 32'(a_irdy), 1);
    chk("rst_b_occ", 32'(b_occ), 0);
    chk("rst_b_addr", b_oaddr, 0);
    rst_n = 1'b1;

    // aligned uncompressed word, 32-bit bus
    ta(1, 0, 32'h100, 0, 0, 0);
    ta(0, 1, 0, 32'h00b50533, 0, 0);
    qa.push_back('{32'h100, 32'h00b50533, FULL, 1'b0});
    @(negedge clk);
`ifdef FETCH_FIFO_BYPASS_EN
    chk("t1_bypass_vld", 32'(a_ovld), 1);
    chk("t1_bypass_data", a_ordata, 32'h00b50533);
`else
    chk("t1_latency_vld", 32'(a_ovld), 0);
`endif
    ta(0, 0, 0, 0, 0, 1);
    @(negedge clk);
    chk("t1_occ1", 32'(a_occ), 1);
    chk("t1_vld", 32'(a_ovld), 1);
    chk("t1_addr", a_oaddr, 32'h100);
    ta(0, 0, 0, 0, 0, 0);
    @(negedge clk);
    chk("t1_occ0", 32'(a_occ), 0);
    chk("t1_addr_next", a_oaddr, 32'h104);
    chk("t1_vld_after", 32'(a_ovld), 0);

    // instruction spanning two words, second word errored
    ta(1, 0, 32'h102, 0, 0, 0);
    ta(0, 1, 0, 32'h05330000, 0, 1);
    qa.push_back('{32'h102, 32'h00b50533, FULL, 1'b1});
    qa.push_back('{32'h106, 32'h00001234, HALF, 1'b1});
    @(negedge clk);
    chk("t3_wait0", 32'(a_ovld), 0);
    ta(0, 0, 0, 0, 0, 1);
    @(negedge clk);
    chk("t3_wait1", 32'(a_ovld), 0);
    ta(0, 0, 0, 0, 0, 1);
    @(negedge clk);
    chk("t3_wait2", 32'(a_ovld), 0);
    ta(0, 1, 0, 32'h123400b5, 1, 1);
    ta(0, 0, 0, 0, 0, 1);
    drain_a("t3_drain");
    ta(0, 0, 0, 0, 0, 0);
    @(negedge clk);
    chk("t3_occ", 32'(a_occ), 0);
    chk("t3_addr_end", a_oaddr, 32'h108);

    // compressed at the misaligned target: error belongs only to later instructions
    ta(1, 0, 32'h102, 0, 0, 0);
    ta(0, 1, 0, 32'h45010000, 0, 1);
    qa.push_back('{32'h102, 32'h00004501, HALF, 1'b0});
    qa.push_back('{32'h104, 32'h000000b5, HALF, 1'b1});
    qa.push_back('{32'h106, 32'h00001234, HALF, 1'b1});
    ta(0, 0, 0, 0, 0, 1);
    ta(0, 0, 0, 0, 0, 1);
    ta(0, 1, 0, 32'h123400b5, 1, 1);
    ta(0, 0, 0, 0, 0, 1);
    drain_a("t4_drain");
    ta(0, 0, 0, 0, 0, 0);

    // occupancy and ready with back-pressure
    ta(1, 0, 32'h300, 0, 0, 0);
    ta(0, 1, 0, 32'h11111113, 0, 0);
    qa.push_back('{32'h300, 32'h11111113, FULL, 1'b0});
    ta(0, 1, 0, 32'h22222223, 0, 0);
    qa.push_back('{32'h304, 32'h22222223, FULL, 1'b0});
    @(negedge clk);
    chk("t5_irdy_one", 32'(a_irdy), 1);
    ta(0, 0, 0, 0, 0, 0);
    @(negedge clk);
    chk("t5_occ2", 32'(a_occ), 2);
    chk("t5_irdy0", 32'(a_irdy), 0);
    ta(0, 0, 0, 0, 0, 1);
    ta(0, 0, 0, 0, 0, 0);
    @(negedge clk);
    chk("t5_occ1", 32'(a_occ), 1);
    chk("t5_irdy1", 32'(a_irdy), 1);
    ta(0, 1, 0, 32'h33333333, 0, 1);
    qa.push_back('{32'h308, 32'h33333333, FULL, 1'b0});
    ta(0, 0, 0, 0, 0, 0);
    @(negedge clk);
    chk("t5_pushpop_occ", 32'(a_occ), 1);
    ta(0, 0, 0, 0, 0, 1);
    drain_a("t5_drain");
    ta(0, 0, 0, 0, 0, 0);
    @(negedge clk);
    chk("t5_occ_end", 32'(a_occ), 0);

    // 64-bit bus: three instructions from one word, pop on the last
    tb(1, 0, 32'h100, 0, 0, 0);
    tb(0, 1, 0, 64'h0001_4501_00b5_0533, 0, 0);
    qb.push_back('{32'h100, 32'h00b50533, FULL, 1'b0});
    qb.push_back('{32'h104, 32'h00004501, HALF, 1'b0});
    qb.push_back('{32'h106, 32'h00000001, HALF, 1'b0});
    tb(0, 0, 0, 0, 0, 1);
    @(negedge clk);
    chk("t2_occ_acc1", 32'(b_occ), 1);
    tb(0, 0, 0, 0, 0, 1);
    @(negedge clk);
    chk("t2_occ_acc2", 32'(b_occ), 1);
    chk("t2_addr_acc2", b_oaddr, 32'h104);
    tb(0, 0, 0, 0, 0, 1);
    @(negedge clk);
    chk("t2_occ_acc3", 32'(b_occ), 1);
    chk("t2_addr_acc3", b_oaddr, 32'h106);
    tb(0, 0, 0, 0, 0, 0);
    @(negedge clk);
    chk("t2_occ_end", 32'(b_occ), 0);
    chk("t2_vld_end", 32'(b_ovld), 0);
    chk("t2_addr_end", b_oaddr, 32'h108);
    chk("t2_pending", qb.size(), 0);

    // clear with occupancy 2 and a concurrent input word
    ta(1, 0, 32'h400, 0, 0, 0);
    ta(0, 1, 0, 32'haaaaaaab, 0, 0);
    ta(0, 1, 0, 32'hbbbbbbbb, 0, 0);
    ta(1, 1, 32'h200, 32'hcccccccf, 0, 0);
    @(negedge clk);
    chk("t6_occ_pre", 32'(a_occ), 2);
    ta(0, 0, 0, 0, 0, 0);
    @(negedge clk);
    chk("t6_clr_occ", 32'(a_occ), 0);
    chk("t6_clr_vld", 32'(a_ovld), 0);
    chk("t6_clr_addr", a_oaddr, 32'h200);

    // asynchronous reset in the middle of a cycle
    ta(0, 1, 0, 32'h00000013, 0, 0);
    ta(0, 0, 0, 0, 0, 0);
    @(negedge clk);
    chk("t6_occ_before_rst", 32'(a_occ), 1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("t6_rst_occ", 32'(a_occ), 0);
    chk("t6_rst_vld", 32'(a_ovld), 0);
    chk("t6_rst_addr", a_oaddr, 0);
    chk("t6_rst_irdy", 32'(a_irdy), 1);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(posedge clk);
    chk("end_pending_a", qa.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
